// File: rtl/ahb_regbank_if.sv
// ---------------------------------------------------------------------------
// ahb_regbank_if -- simplified AHB-style slave bus for the register bank.
//
// Signals:
//   hsel    master -> slave  transfer select, sampled in IDLE
//   hwrite  master -> slave  1 = write, 0 = read (sampled with hsel)
//   haddr   master -> slave  byte address (low 16 bits decoded)
//   hwdata  master -> slave  write data, sampled in the DATA cycle
//   hrdata  slave -> master  read data, valid in the DATA cycle, else 0
//   hready  slave -> master  high exactly in the DATA cycle
// ---------------------------------------------------------------------------
interface ahb_regbank_if;
   logic        hsel;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;

   modport master (output hsel, hwrite, haddr, hwdata, input hrdata, hready);
   modport slave  (input hsel, hwrite, haddr, hwdata, output hrdata, hready);
endinterface

// File: rtl/ahb_regbank.sv
// ---------------------------------------------------------------------------
// ahb_regbank -- bus-accessible register bank with change-detect interrupt.
//
// Address map (haddr[15:0], word aligned):
//   0x000 + 4*i  RW[i]   read/write, i < NRW
//   0x100 + 4*i  RO[i]   read-only view of ro_data channel i, i < NRO
//   0x200        PEND    change-pending bits, write-1-to-clear
//   0x204        MASK    interrupt enable per channel
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   bus      ahb_regbank_if.slave (hsel/hwrite/haddr/hwdata/hrdata/hready)
//   data     NRW*DW  RW register contents, register i at [i*DW +: DW]
//   ro_data  NRO*DW  read-only channel inputs, channel i at [i*DW +: DW]
//   irq      OR of PEND & MASK
//
// Every transfer takes two cycles: IDLE (address/direction captured when
// hsel is high) then DATA (hready=1, read data driven, write committed at
// the closing edge). hsel is ignored during DATA.
// ---------------------------------------------------------------------------
module ahb_regbank #(
   parameter int DW  = 16,
   parameter int NRW = 8,
   parameter int NRO = 8
) (
   input  logic              clk,
   input  logic              rst,
   ahb_regbank_if.slave      bus,
   output logic [NRW*DW-1:0] data,
   input  logic [NRO*DW-1:0] ro_data,
   output logic              irq
);

   typedef enum logic {IDLE, DATA} state_t;

   state_t             state;
   logic [15:0]        addr_q;
   logic               write_q;
   logic               hready_q;

   logic [DW-1:0]      rw_q [NRW];
   logic [NRO-1:0]     pend_q;
   logic [NRO-1:0]     mask_q;
   logic [NRO*DW-1:0]  ro_prev;

   logic [NRW-1:0]     rw_sel;
   logic [NRO-1:0]     ro_sel;
   logic               pend_hit;
   logic               mask_hit;
   logic [31:0]        rd_mux;
   logic               do_write;
   logic [NRO-1:0]     pend_set;
   logic [NRO-1:0]     pend_clr;

   // Upper address bits and the data bits beyond DW/NRO are not decoded;
   // this sink makes that explicit.
   logic unused_bus_bits;
   assign unused_bus_bits = &{1'b0, bus.haddr[31:16], bus.hwdata};

   // ------------------------------------------------------------------------
   // Transfer FSM: captures address/direction on entry to DATA.
   // ------------------------------------------------------------------------
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hready_q <= 1'b0;
         addr_q   <= '0;
         write_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.hsel) begin
                  state    <= DATA;
                  hready_q <= 1'b1;
                  addr_q   <= bus.haddr[15:0];
                  write_q  <= bus.hwrite;
               end
            end
            DATA: begin
               state    <= IDLE;
               hready_q <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               hready_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Address decode of the captured address (exact match, so misaligned
   // and out-of-range addresses fall through as unmapped).
   // ------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      rw_sel = '0;
      ro_sel = '0;
      for (int i = 0; i < NRW; i++) rw_sel[i] = (addr_q == 16'(4 * i));
      for (int i = 0; i < NRO; i++) ro_sel[i] = (addr_q == 16'(256 + 4 * i));
   end

   assign pend_hit = (addr_q == 16'h0200);
   assign mask_hit = (addr_q == 16'h0204);

   // Read mux; RO channels are read live from ro_data during DATA.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NRW; i++)
         if (rw_sel[i]) rd_mux = 32'(rw_q[i]);
      for (int i = 0; i < NRO; i++)
         if (ro_sel[i]) rd_mux = 32'(ro_data[i*DW +: DW]);
      if (pend_hit) rd_mux = 32'(pend_q);
      if (mask_hit) rd_mux = 32'(mask_q);
   end

   assign bus.hready = hready_q;
   assign bus.hrdata = (state == DATA && !write_q) ? rd_mux : '0;

   // ------------------------------------------------------------------------
   // Register file, change detect and interrupt.
   // ------------------------------------------------------------------------
   assign do_write = (state == DATA) && write_q;
   assign pend_clr = (do_write && pend_hit) ? bus.hwdata[NRO-1:0] : '0;

   always_comb begin
      pend_set = '0;
      for (int i = 0; i < NRO; i++)
         pend_set[i] = (ro_data[i*DW +: DW] != ro_prev[i*DW +: DW]);
   end

   // NOTE: the RW array is reset because software relies on reading zeros
   // after reset; ro_prev is deliberately outside the reset branch so it
   // tracks ro_data during reset and no change is flagged on release.
   always_ff @(posedge clk) begin
      ro_prev <= ro_data;
      if (rst) begin
         for (int i = 0; i < NRW; i++) rw_q[i] <= '0;
         pend_q <= '0;
         mask_q <= '0;
      end else begin
         // A new change and a W1C of the same bit collide: set wins.
         pend_q <= (pend_q & ~pend_clr) | pend_set;
         if (do_write) begin
            for (int i = 0; i < NRW; i++)
               if (rw_sel[i]) rw_q[i] <= bus.hwdata[DW-1:0];
            if (mask_hit) mask_q <= bus.hwdata[NRO-1:0];
         end
      end
   end

   always_comb begin
      data = '0;
      for (int i = 0; i < NRW; i++) data[i*DW +: DW] = rw_q[i];
   end

   assign irq = |(pend_q & mask_q);

endmodule

// File: tb/tb_ahb_regbank.sv
// ---------------------------------------------------------------------------
// tb_ahb_regbank -- self-checking bench for ahb_regbank.
//
// A driver issues transfers and keeps a behavioural model of the register
// map; for every DATA cycle it pushes the expected response into a queue.
// A monitor on the falling edge pops an entry whenever hready is high and
// compares hrdata, and compares data/irq against the model every cycle.
// ---------------------------------------------------------------------------
module tb_ahb_regbank;
   localparam int DW  = 16;
   localparam int NRW = 8;
   localparam int NRO = 8;
   localparam int ROW = NRO * DW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NRW*DW-1:0] data;
   logic [ROW-1:0]    ro_data = '0;
   logic              irq;

   ahb_regbank_if bus ();

   ahb_regbank #(.DW(DW), .NRW(NRW), .NRO(NRO)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .data    (data),
      .ro_data (ro_data),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_read;
      logic [15:0] addr;
      logic [31:0] exp;
   } sb_t;

   sb_t sb[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  mon_en   = 1'b0;

   logic           rst_drv = 1'b1;
   logic [ROW-1:0] ro_drv  = '0;

   // Behavioural model of the register map.
   logic [DW-1:0]  m_rw [NRW];
   logic [NRO-1:0] m_pend;
   logic [NRO-1:0] m_mask;
   logic [ROW-1:0] m_ro_prev;
   bit             m_busy;
   logic [15:0]    m_addr;
   bit             m_wr;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [15:0] a);
      int i;
      if (a[1:0] != 2'b00) return '0;
      if (a < 16'h0100) begin
         i = int'(a) / 4;
         return (i < NRW) ? 32'(m_rw[i]) : '0;
      end
      if (a < 16'h0200) begin
         i = (int'(a) - 256) / 4;
         return (i < NRO) ? 32'(ro_data[i*DW +: DW]) : '0;
      end
      if (a == 16'h0200) return 32'(m_pend);
      if (a == 16'h0204) return 32'(m_mask);
      return '0;
   endfunction

   function automatic logic [NRW*DW-1:0] m_data();
      logic [NRW*DW-1:0] r;
      for (int i = 0; i < NRW; i++) r[i*DW +: DW] = m_rw[i];
      return r;
   endfunction

   // Applies the register-map rules for one rising edge, using the inputs
   // present during the cycle that the edge closes.
   task automatic model_edge();
      logic [NRO-1:0] set_bits;
      logic [NRO-1:0] clr_bits;
      if (rst) begin
         for (int i = 0; i < NRW; i++) m_rw[i] = '0;
         m_pend = '0;
         m_mask = '0;
         m_busy = 1'b0;
      end else begin
         set_bits = '0;
         clr_bits = '0;
         for (int i = 0; i < NRO; i++)
            if (ro_data[i*DW +: DW] != m_ro_prev[i*DW +: DW]) set_bits[i] = 1'b1;
         if (m_busy && m_wr) begin
            if (m_addr == 16'h0200)
               clr_bits = bus.hwdata[NRO-1:0];
            else if (m_addr == 16'h0204)
               m_mask = bus.hwdata[NRO-1:0];
            else if (m_addr[1:0] == 2'b00 && int'(m_addr) < 4 * NRW)
               m_rw[int'(m_addr) / 4] = bus.hwdata[DW-1:0];
         end
         m_pend = (m_pend & ~clr_bits) | set_bits;
         if (m_busy)
            m_busy = 1'b0;
         else if (bus.hsel) begin
            m_busy = 1'b1;
            m_addr = bus.haddr[15:0];
            m_wr   = bus.hwrite;
         end
      end
      m_ro_prev = ro_data;
   endtask

   // One clock cycle: update the model at the edge, then drive new inputs.
   task automatic step(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d);
      sb_t e;
      @(posedge clk);
      model_edge();
      #1;
      rst        = rst_drv;
      ro_data    = ro_drv;
      bus.hsel   = s;
      bus.hwrite = w;
      bus.haddr  = a;
      bus.hwdata = d;
      if (m_busy) begin
         e.is_read = !m_wr;
         e.addr    = m_addr;
         e.exp     = m_read(m_addr);
         sb.push_back(e);
      end
      mon_en = 1'b1;
   endtask

   task automatic idle();
      step(1'b0, 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
   endtask

   // Two-cycle transfer; address-phase data and DATA-phase address/hsel are
   // random so only the correctly sampled values can matter.
   task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [ROW-1:0] ro_in_data);
      step(1'b1, wr, a, 32'($urandom));
      ro_drv = ro_in_data;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom), d);
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] a;
      case ($urandom_range(0, 5))
         0:       a = 32'(4 * $urandom_range(0, NRW - 1));
         1:       a = 32'(256 + 4 * $urandom_range(0, NRO - 1));
         2:       a = 32'h200;
         3:       a = 32'h204;
         4:       a = 32'($urandom_range(0, 16'hFFFF));
         default: a = {16'($urandom), 16'(4 * $urandom_range(0, NRW - 1))};
      endcase
      return a;
   endfunction

   function automatic logic [ROW-1:0] set_chan(input logic [ROW-1:0] v, input int ch,
                                               input logic [DW-1:0] val);
      logic [ROW-1:0] r;
      r = v;
      r[ch*DW +: DW] = val;
      return r;
   endfunction

   // Monitor / scoreboard consumer.
   always @(negedge clk) begin
      sb_t e;
      if (mon_en) begin
         if (bus.hready === 1'b1) begin
            if (sb.size() == 0) begin
               check("hready_unexpected", 128'(bus.hready), 128'(0));
            end else begin
               e = sb.pop_front();
               if (e.is_read)
                  check($sformatf("read_%h", e.addr), 128'(bus.hrdata), 128'(e.exp));
            end
         end else begin
            check("hready_idle", 128'(bus.hready), 128'(0));
            check("hrdata_idle", 128'(bus.hrdata), 128'(0));
         end
         check("data", 128'(data), 128'(m_data()));
         check("irq", 128'(irq), 128'(|(m_pend & m_mask)));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]     pat;
      logic [ROW-1:0] ro_mut;

      bus.hsel   = 1'b0;
      bus.hwrite = 1'b0;
      bus.haddr  = '0;
      bus.hwdata = '0;
      for (int i = 0; i < NRW; i++) m_rw[i] = '0;
      m_pend    = '0;
      m_mask    = '0;
      m_ro_prev = '0;
      m_busy    = 1'b0;
      m_addr    = '0;
      m_wr      = 1'b0;

      repeat (3) idle();
      rst_drv = 1'b0;
      idle();
      idle();

      // Write then read RW[2].
      xfer(1'b1, 32'h008, 32'h1234ABCD, ro_drv);
      idle();
      check("rw2_after_write", 128'(data[47:32]), 128'(16'hABCD));
      xfer(1'b0, 32'h008, 32'h0, ro_drv);

      // Channel 3 change with MASK=0x08 raises irq; read back the channel.
      xfer(1'b1, 32'h204, 32'h08, ro_drv);
      idle();
      ro_drv = set_chan(ro_drv, 3, 16'h0055);
      idle();
      idle();
      check("irq_on_change", 128'(irq), 128'(1));
      xfer(1'b0, 32'h10C, 32'h0, ro_drv);
      xfer(1'b0, 32'h200, 32'h0, ro_drv);

      // PEND=0x09, clear bit 0, then clear bit 3 while channel 3 changes.
      ro_drv = set_chan(ro_drv, 0, 16'h1111);
      idle();
      idle();
      xfer(1'b0, 32'h200, 32'h0, ro_drv);
      xfer(1'b1, 32'h200, 32'h01, ro_drv);
      xfer(1'b0, 32'h200, 32'h0, ro_drv);
      xfer(1'b1, 32'h200, 32'h08, set_chan(ro_drv, 3, 16'h00AA));
      idle();
      check("irq_set_wins", 128'(irq), 128'(1));
      xfer(1'b0, 32'h200, 32'h0, ro_drv);

      // Unmapped read and RO write.
      xfer(1'b0, 32'h300, 32'h0, ro_drv);
      xfer(1'b1, 32'h104, 32'hFFFFFFFF, ro_drv);
      xfer(1'b0, 32'h104, 32'h0, ro_drv);
      xfer(1'b0, 32'h002, 32'h0, ro_drv);

      // hsel held for six cycles: three back-to-back transfers.
      pat = '0;
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, pick_addr(), 32'($urandom));
         pat = {pat[4:0], bus.hready};
      end
      check("hready_pattern", 128'(pat), 128'(6'b010101));
      idle();

      // Reset during the DATA cycle of a write to RW[0], ro_data toggling.
      xfer(1'b1, 32'h000, 32'h5A5A, ro_drv);
      idle();
      step(1'b1, 1'b1, 32'h000, 32'($urandom));
      rst_drv = 1'b1;
      ro_drv  = ~ro_drv;
      step(1'b0, 1'b0, 32'h0, 32'h0000BEEF);
      for (int k = 0; k < 3; k++) begin
         ro_drv = ro_drv ^ {NRO{16'($urandom)}};
         idle();
      end
      rst_drv = 1'b0;
      idle();
      idle();
      check("rw0_after_abort", 128'(data[DW-1:0]), 128'(0));
      check("irq_after_reset", 128'(irq), 128'(0));
      xfer(1'b0, 32'h200, 32'h0, ro_drv);
      xfer(1'b0, 32'h000, 32'h0, ro_drv);

      // Randomised traffic.
      for (int n = 0; n < 400; n++) begin
         ro_mut = ro_drv;
         for (int c = 0; c < NRO; c++)
            if ($urandom_range(0, 7) == 0) ro_mut = set_chan(ro_mut, c, 16'($urandom));
         if ($urandom_range(0, 1) == 1) ro_drv = ro_mut;
         xfer(1'($urandom_range(0, 1)), pick_addr(), 32'($urandom), ro_mut);
         if ($urandom_range(0, 3) == 0) idle();
         if ($urandom_range(0, 99) == 0) begin
            rst_drv = 1'b1;
            idle();
            rst_drv = 1'b0;
            idle();
         end
      end

      repeat (4) idle();
      check("scoreboard_drained", 128'(sb.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_regbank.md
AHB_REGBANK -- requirements
Module: ahb_regbank

Interface
REQ-001 Parameter DW, default 16: register data width, legal 1..32.
REQ-002 Parameter NRW, default 8: number of read/write registers, legal 1..32.
REQ-003 Parameter NRO, default 8: number of read-only channels, legal 1..32.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 hsel  input  1  slave select; starts a transfer when sampled high in IDLE.
REQ-007 hwrite  input  1  1 = write, 0 = read; sampled with hsel.
REQ-008 haddr  input  32  byte address; only haddr[15:0] decoded.
REQ-009 hwdata  input  32  write data; sampled in the DATA cycle.
REQ-010 hrdata  output  32  read data; valid in the DATA cycle, else 0.
REQ-011 hready  output  1  high exactly in the DATA cycle.
REQ-012 data  output  NRW*DW  RW register contents; register i at bits [i*DW +: DW].
REQ-013 ro_data  input  NRO*DW  read-only channels; channel i at bits [i*DW +: DW].
REQ-014 irq  output  1  interrupt, OR of pending AND mask.

Function
REQ-015 Address map (haddr[15:0]): RW[i] at 0x000+4*i for i<NRW; RO[i] at 0x100+4*i for i<NRO; PEND at 0x200; MASK at 0x204; all other addresses unmapped.
REQ-016 FSM states: IDLE, DATA; IDLE->DATA when hsel=1; DATA->IDLE unconditionally.
REQ-017 On the IDLE->DATA edge, haddr[15:0] and hwrite shall be captured; the captured values govern the DATA cycle.
REQ-018 hsel in DATA state shall be ignored; maximum throughput is one transfer per 2 cycles.
REQ-019 Read, in DATA with captured hwrite=0: hrdata = selected register zero-extended to 32 bits (RW[i], RO[i] = current ro_data channel i, PEND[NRO-1:0], MASK[NRO-1:0]); unmapped -> 0.
REQ-020 Write, at the clock edge ending DATA with captured hwrite=1: RW[i] <= hwdata[DW-1:0]; MASK <= hwdata[NRO-1:0]; PEND bits where hwdata=1 are cleared (write-1-to-clear); RO and unmapped writes are discarded.
REQ-021 A write updates the data output on the cycle after DATA (one-cycle write latency).
REQ-022 Change detect: ro_prev shall register ro_data every cycle; PEND[i] sets on any cycle where channel i of ro_data differs from ro_prev channel i.
REQ-023 PEND set and W1C clear of the same bit in the same cycle: set wins.
REQ-024 irq = |(PEND & MASK), combinational from registers; no extra latency beyond PEND/MASK updates.
REQ-025 hrdata and hready shall be 0 in IDLE.

Reset
REQ-026 While rst=1: FSM -> IDLE, all RW registers = 0, PEND = 0, MASK = 0, hready = 0, hrdata = 0, irq = 0.
REQ-027 While rst=1, ro_prev shall load ro_data each cycle so that no PEND bit sets on the first cycle after reset release.
REQ-028 rst asserted during DATA shall abort the transfer; the pending write is discarded.

Verification
REQ-029 Write 0x1234ABCD to 0x008, then read 0x008 -> data[47:32]=0xABCD one cycle after DATA; read returns hrdata=0x0000ABCD with hready=1.
REQ-030 ro_data channel 3 changes 0x0000->0x0055, MASK=0x08 -> PEND=0x08 next cycle, irq=1; read 0x10C returns 0x00000055.
REQ-031 PEND=0x09, write 0x01 to 0x200 -> PEND=0x08; write 0x08 in same cycle channel 3 changes again -> PEND bit 3 stays 1.
REQ-032 Read 0x300 and write 0x104 -> hrdata=0, no register or data change.
REQ-033 hsel held high for 6 cycles -> exactly 3 transfers, hready pattern 0,1,0,1,0,1.
REQ-034 rst asserted in DATA of write to 0x000 with ro_data toggling -> RW[0]=0, PEND=0 one cycle after rst release.
